banderin_control: RTL and testbench

BANDERIN_CONTROL -- requirements
Module: banderin_control

---
 rtl/banderin_if.sv | 23 ++
 rtl/banderin_control.sv | 136 +++++++++++++
 tb/tb_banderin_control.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/banderin_if.sv
// Signal bundle between the race-flag controller and its surroundings:
// three raw push-button/photogate inputs in, flag/race status out.
interface banderin_if;
  logic       btn_start;
  logic       btn_abort;
  logic       sensor_meta;
  logic       comando_banderin;
  logic       carrera_activa;
  logic       carrera_fin;
  logic [1:0] estado;

  // Environment side: drives the raw inputs, observes the controller.
  modport master (
    output btn_start, btn_abort, sensor_meta,
    input  comando_banderin, carrera_activa, carrera_fin, estado
  );

  // Controller side.
  modport slave (
    input  btn_start, btn_abort, sensor_meta,
    output comando_banderin, carrera_activa, carrera_fin, estado
  );
endinterface

// File: rtl/banderin_control.sv
// Race start/finish flag controller. Synchronizes and debounces the start
// button, abort button and finish-line photogate, turns their rising edges
// into single-cycle events and sequences the flag through
// IDLE -> SUBIENDO (flag raised, hold) -> CARRERA (timing) -> FIN (flag
// lowered, hold) -> IDLE.
module banderin_control #(
  parameter int DEBOUNCE_CLKS = 250_000,
  parameter int HOLD_CLKS     = 50_000_000
) (
  input  logic      clk,
  input  logic      reset,
  banderin_if.slave bus
);

  localparam int DB_W   = (DEBOUNCE_CLKS > 1) ? $clog2(DEBOUNCE_CLKS) : 1;
  localparam int HOLD_W = (HOLD_CLKS > 1) ? $clog2(HOLD_CLKS) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CLKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CLKS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SUBIENDO = 2'b01,
    CARRERA  = 2'b10,
    FIN      = 2'b11
  } state_t;

  // Channel order: 0 = start, 1 = abort, 2 = meta.
  logic [2:0]      raw;
  logic [2:0]      sync1, sync2;
  logic [2:0]      deb, deb_q;
  logic [DB_W-1:0] db_cnt [3];

  logic start_ev, abort_ev, meta_ev;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              comando_q, activa_q, fin_q;

  assign raw = {bus.sensor_meta, bus.btn_abort, bus.btn_start};

  // Two-flop synchronizer for each asynchronous input.
  always_ff @(posedge clk) begin
    // NOTE: every register uses non-blocking assignment so all flops update
    // from pre-edge values; blocking here would collapse the two stages.
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-channel debouncer: level follows the synced input only after it
  // has differed for DEBOUNCE_CLKS consecutive cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb   <= '0;
      deb_q <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // cleared on reset like any other register.
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      deb_q <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Rising edges of the debounced levels; falling edges are ignored.
  assign start_ev = deb[0] & ~deb_q[0];
  assign abort_ev = deb[1] & ~deb_q[1];
  assign meta_ev  = deb[2] & ~deb_q[2];

  // Flag sequencer with registered outputs; abort beats start and meta.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      comando_q <= 1'b0;
      activa_q  <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      fin_q <= 1'b0;
      if (abort_ev) begin
        // Also swallows a coincident start while already idle.
        state     <= IDLE;
        comando_q <= 1'b0;
        activa_q  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_ev) begin
              state     <= SUBIENDO;
              hold_cnt  <= '0;
              comando_q <= 1'b1;
              activa_q  <= 1'b1;
            end
          end
          SUBIENDO: begin
            if (hold_cnt == HOLD_LAST) state <= CARRERA;
            else hold_cnt <= hold_cnt + HOLD_W'(1);
          end
          CARRERA: begin
            if (meta_ev) begin
              state     <= FIN;
              hold_cnt  <= '0;
              comando_q <= 1'b0;
              activa_q  <= 1'b0;
              fin_q     <= 1'b1;
            end
          end
          FIN: begin
            if (hold_cnt == HOLD_LAST) state <= IDLE;
            else hold_cnt <= hold_cnt + HOLD_W'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.comando_banderin = comando_q;
  assign bus.carrera_activa   = activa_q;
  assign bus.carrera_fin      = fin_q;
  assign bus.estado           = state;

endmodule

// File: tb/tb_banderin_control.sv
// Self-checking bench for banderin_control: a cycle-level behavioural model
// (input delay line, run-length debounce, timestamped holds) compared every
// cycle, plus directed scenarios with hand-computed cycle counts.
module tb_banderin_control;
  localparam int DEB  = 4;
  localparam int HOLD = 10;

  logic clk = 1'b0;
  logic reset;
  banderin_if bus ();

  banderin_control #(.DEBOUNCE_CLKS(DEB), .HOLD_CLKS(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int       cyc = 0;
  int       t_enter = 0;
  int       m_st = 0;       // 0 idle, 1 raising, 2 racing, 3 finished
  bit       m_fin = 1'b0;
  bit [2:0] m_in, m_d1 = '0, m_d2 = '0, m_deb = '0, m_prev = '0, ev;
  int       m_run [3] = '{0, 0, 0};

  always @(posedge clk) begin
    cyc++;
    m_in = {bus.sensor_meta, bus.btn_abort, bus.btn_start};
    if (reset) begin
      m_st = 0; m_fin = 1'b0;
      m_d1 = '0; m_d2 = '0; m_deb = '0; m_prev = '0;
      for (int k = 0; k < 3; k++) m_run[k] = 0;
    end else begin
      ev    = m_deb & ~m_prev;
      m_fin = 1'b0;
      if (ev[1]) m_st = 0;
      else begin
        case (m_st)
          0: if (ev[0]) begin m_st = 1; t_enter = cyc; end
          1: if (cyc - t_enter == HOLD) m_st = 2;
          2: if (ev[2]) begin m_st = 3; t_enter = cyc; m_fin = 1'b1; end
          default: if (cyc - t_enter == HOLD) m_st = 0;
        endcase
      end
      m_prev = m_deb;
      for (int k = 0; k < 3; k++) begin
        if (m_d2[k] != m_deb[k]) begin
          m_run[k]++;
          if (m_run[k] == DEB) begin m_deb[k] = m_d2[k]; m_run[k] = 0; end
        end else m_run[k] = 0;
      end
      m_d2 = m_d1;
      m_d1 = m_in;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("estado", int'(bus.estado), m_st);
      check("comando_banderin", int'(bus.comando_banderin), int'(m_st == 1 || m_st == 2));
      check("carrera_activa", int'(bus.carrera_activa), int'(m_st == 1 || m_st == 2));
      check("carrera_fin", int'(bus.carrera_fin), int'(m_fin));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int ch, input logic v);
    case (ch)
      0: bus.btn_start = v;
      1: bus.btn_abort = v;
      default: bus.sensor_meta = v;
    endcase
  endtask

  task automatic press(input int ch, input int n);
    drive(ch, 1'b1);
    repeat (n) @(negedge clk);
    drive(ch, 1'b0);
  endtask

  task automatic wait_estado(input logic [1:0] tgt, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (bus.estado == tgt) begin n = i; break; end
    end
  endtask

  int t_sub, t_car, t_fin, t_idle, fin_cnt, n;
  int left [3];
  logic lvl;

  initial begin
    bus.btn_start = 0; bus.btn_abort = 0; bus.sensor_meta = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_estado", int'(bus.estado), 0);
    check("rst_comando", int'(bus.comando_banderin), 0);
    check("rst_activa", int'(bus.carrera_activa), 0);
    check("rst_fin", int'(bus.carrera_fin), 0);
    reset = 1'b0;

    // Glitch: 3-cycle start pulse must be rejected.
    press(0, 3);
    repeat (12) @(negedge clk);
    check("glitch_estado", int'(bus.estado), 0);
    check("glitch_comando", int'(bus.comando_banderin), 0);

    // Start flow with a photogate pulse during the raise hold.
    t_sub = 0; t_car = 0;
    bus.btn_start = 1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 10) bus.btn_start = 0;
      if (t_sub != 0 && i == t_sub + 6) bus.sensor_meta = 0;
      if (t_sub == 0 && bus.estado == 2'b01) begin
        t_sub = i;
        check("sub_comando", int'(bus.comando_banderin), 1);
        check("sub_activa", int'(bus.carrera_activa), 1);
        bus.sensor_meta = 1;
      end
      if (t_car == 0 && bus.estado == 2'b10) t_car = i;
    end
    check("start_latency_ok", int'(t_sub >= 6 && t_sub <= 8), 1);
    check("start_latency", t_sub, 7);
    check("raise_hold", t_car - t_sub, HOLD);
    check("masked_meta_estado", int'(bus.estado), 2);

    // Finish detection and lower hold.
    t_fin = 0; t_idle = 0; fin_cnt = 0;
    bus.sensor_meta = 1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 6) bus.sensor_meta = 0;
      if (bus.carrera_fin) fin_cnt++;
      if (t_fin == 0 && bus.estado == 2'b11) begin
        t_fin = i;
        check("fin_pulse", int'(bus.carrera_fin), 1);
        check("fin_comando", int'(bus.comando_banderin), 0);
      end
      if (t_fin != 0 && t_idle == 0 && bus.estado == 2'b00) t_idle = i;
    end
    check("fin_latency", t_fin, 7);
    check("fin_pulse_count", fin_cnt, 1);
    check("lower_hold", t_idle - t_fin, HOLD);

    // Abort and meta in the same cycle while racing.
    press(0, 6);
    wait_estado(2'b10, 40, n);
    check("reach_carrera_abort", int'(n > 0), 1);
    bus.sensor_meta = 1; bus.btn_abort = 1;
    t_idle = 0; fin_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 6) begin bus.sensor_meta = 0; bus.btn_abort = 0; end
      if (bus.carrera_fin) fin_cnt++;
      if (t_idle == 0 && bus.estado == 2'b00) t_idle = i;
    end
    check("abort_latency", t_idle, 7);
    check("abort_no_fin", fin_cnt, 0);

    // Reset at hold count 5 inside FIN.
    press(0, 6);
    wait_estado(2'b10, 40, n);
    check("reach_carrera_rst", int'(n > 0), 1);
    press(2, 6);
    wait_estado(2'b11, 20, n);
    check("reach_fin_rst", int'(n > 0), 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstfin_estado", int'(bus.estado), 0);
    check("rstfin_comando", int'(bus.comando_banderin), 0);
    check("rstfin_activa", int'(bus.carrera_activa), 0);
    check("rstfin_fin", int'(bus.carrera_fin), 0);
    reset = 1'b0;

    // Randomized segments of held levels with occasional resets.
    for (int k = 0; k < 3; k++) left[k] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 499) == 0);
      for (int k = 0; k < 3; k++) begin
        if (left[k] == 0) begin
          lvl = ($urandom_range(0, (k == 1) ? 7 : 2) == 0);
          left[k] = $urandom_range(1, 14);
          drive(k, lvl);
        end else begin
          left[k]--;
        end
      end
    end
    reset = 1'b0;
    bus.btn_start = 0; bus.btn_abort = 0; bus.sensor_meta = 0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
